result_writeback: RTL and testbench

Downstream stage of the half-precision adder datapath: captures each 16-bit result (1 sign, 5 exponent, 10 mantissa) produced by the result-assembly stage, tags it with its operand-pair memory address and an IEEE-754 class code, buffers it in a small FIFO, and writes it to result memory through a request/acknowledge port at consecutive addresses. It decouples the adder's one-result-per-operation cadence from a memory port that may stall.

---
 rtl/fp16_pkg.sv | 28 ++
 rtl/fp16_classify.sv | 33 +++
 rtl/result_writeback.sv | 128 ++++++++++++
 tb/tb_result_writeback.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared half-precision definitions: field widths, class codes,
// writeback FSM states and the buffered writeback entry layout.
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;

    localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;

    localparam logic [3:0] CLS_NORMAL = 4'b0000;
    localparam logic [3:0] CLS_ZERO   = 4'b0001;
    localparam logic [3:0] CLS_SUBN   = 4'b0010;
    localparam logic [3:0] CLS_INF    = 4'b0100;
    localparam logic [3:0] CLS_NAN    = 4'b1000;

    typedef enum logic {
        ST_IDLE,
        ST_WRITE
    } wb_state_e;

    typedef struct packed {
        logic [3:0]  cls;
        logic [3:0]  rsvd;
        logic [7:0]  endereco;
        logic [15:0] resultado;
    } wb_entry_t;

endpackage

// File: rtl/fp16_classify.sv
// One-hot IEEE-754 class of a half-precision value
// (all zeros for a normal number).
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0] value,
    output logic [3:0]  cls
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             exp_zero;
    logic             exp_max;
    logic             man_zero;

    assign exp_f    = value[14:10];
    assign man_f    = value[9:0];
    assign exp_zero = (exp_f == '0);
    assign exp_max  = (exp_f == EXP_MAX);
    assign man_zero = (man_f == '0);

    always_comb begin
        cls = CLS_NORMAL;
        unique case (1'b1)
            exp_zero && man_zero:  cls = CLS_ZERO;
            exp_zero && !man_zero: cls = CLS_SUBN;
            exp_max && man_zero:   cls = CLS_INF;
            exp_max && !man_zero:  cls = CLS_NAN;
            default:               cls = CLS_NORMAL;
        endcase
    end

endmodule

// File: rtl/result_writeback.sv
// Buffers classified adder results in a small FIFO and writes them
// to result memory at consecutive addresses over a req/ack port.
module result_writeback
    import fp16_pkg::*;
#(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            in_resultado,
    input  logic [7:0]             in_endereco,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [31:0]            wr_data,
    input  logic                   wr_ack,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    wb_entry_t             mem_q [DEPTH];
    wb_entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      rd_nxt;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [7:0]            drop_q, drop_d;
    wb_state_e             state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    wb_entry_t             wr_data_q, wr_data_d;
    wb_entry_t             new_entry, next_head;
    logic [3:0]            cls;
    logic                  full, push, pop;

    fp16_classify u_classify (
        .value (in_resultado),
        .cls   (cls)
    );

    always_comb begin
        full      = (count_q == FULL_CNT);
        push      = in_valid && !full;
        pop       = (state_q == ST_WRITE) && wr_ack;
        new_entry = '{cls: cls, rsvd: 4'b0, endereco: in_endereco,
                      resultado: in_resultado};
        rd_nxt    = rd_ptr_q + 1'b1;
        // The next head may be the entry being written this very cycle.
        next_head = (count_q == ONE_CNT && push) ? new_entry : mem_q[rd_nxt];

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
        end
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        drop_d   = (in_valid && full && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

        state_d   = state_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_ptr_d  = rd_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d   = ST_WRITE;
                    wr_en_d   = 1'b1;
                    wr_data_d = mem_q[rd_ptr_q];
                end
            end
            ST_WRITE: begin
                if (pop) begin
                    rd_ptr_d  = rd_nxt;
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (count_d != '0) begin
                        wr_data_d = next_head;
                    end else begin
                        state_d = ST_IDLE;
                        wr_en_d = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            drop_q    <= '0;
            state_q   <= ST_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= BASE_ADDR;
            wr_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign in_ready   = !full;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign count      = count_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_result_writeback.sv
// Scoreboard bench for result_writeback: random and directed traffic
// against a queue-based reference model of the writeback buffer.
module tb_result_writeback;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_resultado = '0;
    logic [7:0]  in_endereco = '0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack = 1'b0;
    logic [2:0]  count;
    logic [7:0]  drop_count;

    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [15:0] b_res = '0;
    logic [7:0]  b_end = '0;
    logic        b_wr_en;
    logic [7:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ack = 1'b0;
    logic [2:0]  b_count;
    logic [7:0]  b_drop;

    always #5 clock = ~clock;

    result_writeback dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_resultado(in_resultado), .in_endereco(in_endereco), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .count(count),
        .drop_count(drop_count)
    );

    result_writeback #(.DEPTH(4), .ADDR_WIDTH(8), .BASE_ADDR(8'hFE)) dut_b (
        .clock(clock), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
        .in_resultado(b_res), .in_endereco(b_end), .wr_en(b_wr_en),
        .wr_addr(b_addr), .wr_data(b_data), .wr_ack(b_ack), .count(b_count),
        .drop_count(b_drop)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list of expected writes plus occupancy.
    typedef struct {
        logic [31:0] data;
        logic [7:0]  addr;
    } exp_t;

    exp_t       exp_q[$];
    int         mcount = 0;
    int         mdrop = 0;
    logic [7:0] maddr = 8'h00;

    function automatic logic [3:0] ref_class(input logic [15:0] r);
        int e;
        int m;
        e = int'(r[14:10]);
        m = int'(r[9:0]);
        if (e == 0) return (m == 0) ? 4'd1 : 4'd2;
        if (e == 31) return (m == 0) ? 4'd4 : 4'd8;
        return 4'd0;
    endfunction

    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            exp_q.delete();
            mcount = 0;
            mdrop = 0;
            maddr = 8'h00;
        end else begin
            int popped;
            exp_t e;
            popped = (wr_en && wr_ack) ? 1 : 0;
            if (in_valid) begin
                if (mcount == 4) begin
                    if (mdrop < 255) mdrop++;
                end else begin
                    e.data = {ref_class(in_resultado), 4'b0, in_endereco, in_resultado};
                    e.addr = maddr;
                    exp_q.push_back(e);
                    maddr = maddr + 8'd1;
                    mcount++;
                end
            end
            mcount -= popped;
        end
    end

    // Monitor: compares state every cycle and each accepted write.
    int idle_run = 0;
    initial forever begin
        @(negedge clock);
        if (reset) begin
            chk("count", 32'(count), 32'(mcount));
            chk("in_ready", 32'(in_ready), 32'(mcount != 4));
            chk("drop_count", 32'(drop_count), 32'(mdrop));
            if (mcount != 0 && !wr_en) idle_run++;
            else idle_run = 0;
            if (idle_run > 1) chk("write_start", 32'(wr_en), 32'd1);
            if (wr_en && wr_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(wr_en), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_data", wr_data, e.data);
                    chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                end
            end
        end else begin
            idle_run = 0;
        end
    end

    logic [7:0] b_seen[$];
    initial forever begin
        @(negedge clock);
        if (reset && b_wr_en && b_ack) b_seen.push_back(b_addr);
    end

    task automatic cyc(input logic v, input logic [15:0] r,
                       input logic [7:0] e, input logic ack);
        in_valid = v;
        in_resultado = r;
        in_endereco = e;
        wr_ack = ack;
        @(posedge clock);
        #2;
    endtask

    logic [15:0] cls_vals [4];

    initial begin
        cls_vals[0] = 16'h0000;
        cls_vals[1] = 16'h0001;
        cls_vals[2] = 16'h7C00;
        cls_vals[3] = 16'h7E00;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h00);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_b_addr", 32'(b_addr), 32'hFE);
        #1 reset = 1'b1;
        @(posedge clock);
        #2;

        // Single result, ack held high
        cyc(1'b1, 16'h3C00, 8'h04, 1'b1);
        chk("t1_no_wr_yet", 32'(wr_en), 32'd0);
        cyc(1'b0, 16'h0, 8'h0, 1'b1);
        chk("t1_wr_en", 32'(wr_en), 32'd1);
        chk("t1_wr_addr", 32'(wr_addr), 32'h00);
        chk("t1_wr_data", wr_data, 32'h0004_3C00);
        cyc(1'b0, 16'h0, 8'h0, 1'b1);
        chk("t1_addr_next", 32'(wr_addr), 32'h01);
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_idle", 32'(wr_en), 32'd0);

        // Classification
        for (int i = 0; i < 4; i++) cyc(1'b1, cls_vals[i], 8'(i), 1'b1);
        repeat (6) cyc(1'b0, 16'h0, 8'h0, 1'b1);

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 16'h4000 + 16'(i), 8'h10 + 8'(i), 1'b0);
            if (i == 3) chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        cyc(1'b0, 16'h0, 8'h0, 1'b0);
        chk("bp_drop", 32'(drop_count), 32'd1);
        chk("bp_hold", wr_data, 32'h0010_4000);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 16'h0, 8'h0, 1'b1);
            chk("bp_b2b", 32'(wr_en), 32'(i < 3));
        end

        // Full with simultaneous pop and push
        for (int i = 0; i < 4; i++) cyc(1'b1, 16'h5000 + 16'(i), 8'h20, 1'b0);
        chk("full_count", 32'(count), 32'd4);
        cyc(1'b1, 16'h5555, 8'h2F, 1'b1);
        chk("fpp_count", 32'(count), 32'd3);
        chk("fpp_drop", 32'(drop_count), 32'd2);
        repeat (6) cyc(1'b0, 16'h0, 8'h0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] r;
            int sel;
            r = 16'($urandom);
            sel = $urandom_range(0, 7);
            if (sel == 0) r[14:10] = 5'd0;
            if (sel == 1) r[14:10] = 5'h1F;
            if (sel < 2 && $urandom_range(0, 1) == 1) r[9:0] = '0;
            cyc($urandom_range(0, 99) < 70, r, 8'($urandom),
                $urandom_range(0, 99) < 50);
        end
        repeat (8) cyc(1'b0, 16'h0, 8'h0, 1'b1);
        chk("drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a pending write
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h4400 + 16'(i), 8'h30, 1'b0);
        cyc(1'b0, 16'h0, 8'h0, 1'b0);
        chk("mr_pre_wr_en", 32'(wr_en), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mr_wr_en", 32'(wr_en), 32'd0);
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_wr_addr", 32'(wr_addr), 32'h00);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        #2 reset = 1'b1;
        @(posedge clock);
        #2;
        chk("mr_drop", 32'(drop_count), 32'd0);
        cyc(1'b1, 16'h3C00, 8'h44, 1'b1);
        repeat (3) cyc(1'b0, 16'h0, 8'h0, 1'b1);
        chk("mr_after", 32'(exp_q.size()), 32'd0);

        // Address wrap from a high base address
        b_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1;
            b_res = 16'h3C00 + 16'(i);
            @(posedge clock);
            #2;
        end
        b_valid = 1'b0;
        repeat (8) begin
            @(posedge clock);
            #2;
        end
        chk("wrap_n", 32'(b_seen.size()), 32'd3);
        if (b_seen.size() == 3) begin
            chk("wrap_a0", 32'(b_seen[0]), 32'hFE);
            chk("wrap_a1", 32'(b_seen[1]), 32'hFF);
            chk("wrap_a2", 32'(b_seen[2]), 32'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
